unidade_busca: RTL

- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and runs a req/ack handshake with instruction memory.
- Presents one fetched instruction (opcode in bits 31:26) with its PC and PC+4 to decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute and squashes any fetched instruction that is no longer valid.

---
 rtl/unidade_busca.sv | 75 +++++++
 1 files changed

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage with imem req/ack, decode valid/ready and redirect squash
module unidade_busca #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {ISSUE, HOLD, DRAIN} state_t;
  state_t state;
  logic [31:0] pc, target, rpc;
  assign rpc = redirect_pc & ~32'h3;
  // pc only moves when no request is outstanding, so it doubles as the fetch address
  assign imem_addr = pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ISSUE;
      pc          <= PC_RESET;
      target      <= '0;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      pc_plus4    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
            if (redirect) pc <= rpc;
          end else if (imem_ack) begin
            if (redirect) pc <= rpc;
            else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc_plus4    <= pc + 32'd4;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end else if (redirect) begin
            target <= rpc;
            state  <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect || instr_ready) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= ISSUE;
            if (redirect) pc <= rpc;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc    <= redirect ? rpc : target;
            state <= ISSUE;
          end else if (redirect) target <= rpc;
        end
        default: state <= ISSUE;
      endcase
    end
  end
endmodule
